// File: rtl/div_iter_pkg.sv
// rtl/div_iter_pkg.sv - shared widths, op fields, FSM states and word-extension helpers for div_iter
package div_iter_pkg;

  localparam int XLEN         = 64;
  localparam int WLEN         = 32;
  localparam int DIV_OP_WIDTH = 3;
  localparam int DIV_SIGNED   = 0;
  localparam int DIV_REM      = 1;
  localparam int DIV_WORD     = 2;
  localparam int DIV_CNT_W    = 7;

  localparam logic [DIV_CNT_W-1:0] DIV_CNT_FULL_LAST = DIV_CNT_W'(XLEN - 1);
  localparam logic [DIV_CNT_W-1:0] DIV_CNT_WORD_LAST = DIV_CNT_W'(WLEN - 1);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic is_word;
    logic is_rem;
    logic is_signed;
  } div_op_t;

  function automatic logic [XLEN-1:0] sext_word(input logic [WLEN-1:0] v);
    return {{(XLEN-WLEN){v[WLEN-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext_word(input logic [WLEN-1:0] v);
    return {{(XLEN-WLEN){1'b0}}, v};
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one combinational restoring-division step: trial subtract and quotient bit
module div_restore_step #(
  parameter int W = 64
) (
  input  logic [W:0]   i_part,
  input  logic [W-1:0] i_div,
  output logic [W-1:0] o_rem,
  output logic         o_qbit
);

  logic [W:0] w_sub;

  // A set top bit means the partial remainder already exceeds any W-bit divisor.
  assign w_sub  = {1'b0, i_part[W-1:0]} - {1'b0, i_div};
  assign o_qbit = i_part[W] | ~w_sub[W];
  assign o_rem  = o_qbit ? w_sub[W-1:0] : i_part[W-1:0];

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - multi-cycle radix-2 restoring divider for div/divu/rem/remu and word forms
module div_iter
  import div_iter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIV_OP_WIDTH-1:0] in_op,
  input  logic [XLEN-1:0]         in_src1,
  input  logic [XLEN-1:0]         in_src2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_result
);

  div_state_e           r_state;
  div_state_e           w_next;
  logic                 r_is_word;
  logic                 r_is_rem;
  logic                 r_q_neg;
  logic                 r_r_neg;
  logic [XLEN-1:0]      r_rem;
  logic [XLEN-1:0]      r_quo;
  logic [XLEN-1:0]      r_div;
  logic [XLEN-1:0]      r_result;
  logic [DIV_CNT_W-1:0] r_cnt;

  div_op_t         w_op;
  logic            w_accept;
  logic            w_s1;
  logic            w_s2;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_special;
  logic            w_last;
  logic            w_qbit;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_a_res;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic [XLEN-1:0] w_spec_res;
  logic [XLEN-1:0] w_step_rem;
  logic [XLEN-1:0] w_q_fin;
  logic [XLEN-1:0] w_q_sgn;
  logic [XLEN-1:0] w_r_sgn;
  logic [XLEN-1:0] w_calc_pre;
  logic [XLEN-1:0] w_calc_res;

  assign w_op     = div_op_t'(in_op);
  assign w_accept = in_valid & in_ready & ~flush;

  always_comb begin
    w_a     = in_src1;
    w_b     = in_src2;
    w_a_res = in_src1;
    if (w_op.is_word) begin
      w_a     = w_op.is_signed ? sext_word(in_src1[WLEN-1:0]) : zext_word(in_src1[WLEN-1:0]);
      w_b     = w_op.is_signed ? sext_word(in_src2[WLEN-1:0]) : zext_word(in_src2[WLEN-1:0]);
      w_a_res = sext_word(in_src1[WLEN-1:0]);
    end
  end

  assign w_s1    = w_op.is_signed & w_a[XLEN-1];
  assign w_s2    = w_op.is_signed & w_b[XLEN-1];
  assign w_mag_a = w_s1 ? -w_a : w_a;
  assign w_mag_b = w_s2 ? -w_b : w_b;

  // Zero/all-ones tests on the extended operands cover both widths.
  assign w_div_zero = (w_b == '0);
  assign w_ovf      = w_op.is_signed & (w_b == '1) &
                      (w_a == (w_op.is_word ? sext_word({1'b1, {(WLEN-1){1'b0}}})
                                            : {1'b1, {(XLEN-1){1'b0}}}));
  assign w_special  = w_div_zero | w_ovf;

  always_comb begin
    w_spec_res = '0;
    if (w_div_zero) begin
      w_spec_res = w_op.is_rem ? w_a_res : '1;
    end else if (!w_op.is_rem) begin
      w_spec_res = w_a_res;
    end
  end

  div_restore_step #(.W(XLEN)) u_step (
    .i_part (({r_rem, r_quo[XLEN-1]})),
    .i_div  (r_div),
    .o_rem  (w_step_rem),
    .o_qbit (w_qbit)
  );

  assign w_last     = (r_cnt == (r_is_word ? DIV_CNT_WORD_LAST : DIV_CNT_FULL_LAST));
  assign w_q_fin    = {r_quo[XLEN-2:0], w_qbit};
  assign w_q_sgn    = r_q_neg ? -w_q_fin : w_q_fin;
  assign w_r_sgn    = r_r_neg ? -w_step_rem : w_step_rem;
  assign w_calc_pre = r_is_rem ? w_r_sgn : w_q_sgn;
  assign w_calc_res = r_is_word ? sext_word(w_calc_pre[WLEN-1:0]) : w_calc_pre;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DIV_IDLE: if (w_accept) w_next = w_special ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (w_last) w_next = DIV_DONE;
      DIV_DONE: if (out_ready) w_next = DIV_IDLE;
      default:  w_next = DIV_IDLE;
    endcase
    if (flush) begin
      w_next = DIV_IDLE;
    end
  end

  always_comb begin
    in_ready  = (r_state == DIV_IDLE);
    out_valid = (r_state == DIV_DONE);
  end

  assign out_result = r_result;

  // Word operands are pre-shifted to the top so the same MSB-first step serves both widths.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_word <= 1'b0;
      r_is_rem  <= 1'b0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      r_is_word <= w_op.is_word;
      r_is_rem  <= w_op.is_rem;
      r_q_neg   <= w_s1 ^ w_s2;
      r_r_neg   <= w_s1;
      r_rem     <= '0;
      r_quo     <= w_op.is_word ? {w_mag_a[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : w_mag_a;
      r_div     <= w_mag_b;
      r_cnt     <= '0;
      if (w_special) begin
        r_result <= w_spec_res;
      end
    end else if (r_state == DIV_CALC) begin
      r_rem <= w_step_rem;
      r_quo <= w_q_fin;
      r_cnt <= r_cnt + DIV_CNT_W'(1);
      if (w_last) begin
        r_result <= w_calc_res;
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - directed and randomized self-checking bench for div_iter
module tb_div_iter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [63:0] in_src1;
  logic [63:0] in_src2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;

  int n_assert = 0;
  int n_fail   = 0;

  div_iter dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // op = {is_word, is_rem, is_signed}; results follow the RV64M rules.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, q32, r32, res32;
    logic [63:0] q, r;
    a32 = a[31:0];
    b32 = b[31:0];
    if (op[2]) begin
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32;
      end else if (op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0;
      end else if (op[0]) begin
        q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      res32 = op[1] ? r32 : q32;
      return {{32{res32[31]}}, res32};
    end
    if (b == 64'd0) begin
      q = '1; r = a;
    end else if (op[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q = a; r = 64'd0;
    end else if (op[0]) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op[2]) begin
      if (b[31:0] == 32'd0) return 1;
      if (op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    if (b == 64'd0) return 1;
    if (op[0] && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
    return 65;
  endfunction

  // Issue one op from IDLE, wait for the result, check latency and value, then take it.
  task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input string tag);
    int k;
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op    = 3'($urandom);
    in_src1  = {$urandom, $urandom};
    in_src2  = {$urandom, $urandom};
    k = 1;
    while (!out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_lat"}, 64'(k), 64'(ref_lat(op, a, b)));
    check({tag, "_res"}, out_result, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [2:0]  op;
    logic [63:0] a, b;
    logic        rose;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_src1 = '0; in_src2 = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_result", out_result, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(3'b000, 64'd100, 64'd7, 64'd14, "divu_100_7");
    do_op(3'b010, 64'd100, 64'd7, 64'd2, "remu_100_7");
    do_op(3'b001, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2");
    do_op(3'b011, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, "rem_m7_2");
    do_op(3'b001, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, "div_5_0");
    do_op(3'b011, 64'd5, 64'd0, 64'd5, "rem_5_0");
    do_op(3'b001, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, "div_ovf");
    do_op(3'b011, 64'h8000_0000_0000_0000, '1, 64'd0, "rem_ovf");
    do_op(3'b100, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, "divuw_ff_1");
    do_op(3'b111, 64'h1_0000_0007, 64'h1_0000_0002, 64'd1, "remw_lowwords");
    do_op(3'b101, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, "divw_ovf");
    do_op(3'b110, 64'hABCD_8000_0000, 64'h5_0000_0000, 64'hFFFF_FFFF_8000_0000, "remuw_by0");

    // Flush at the tenth CALC cycle discards the op.
    in_valid = 1'b1; in_op = 3'b000; in_src1 = 64'd1000; in_src2 = 64'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("calc_in_ready", {63'd0, in_ready}, 64'd0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    rose = 1'b0;
    repeat (70) begin
      rose = rose | out_valid;
      @(posedge clk); #1;
    end
    check("flush_no_valid", {63'd0, rose}, 64'd0);
    do_op(3'b000, 64'd9, 64'd3, 64'd3, "divu_9_3");

    // Flush beats a simultaneous request.
    in_valid = 1'b1; flush = 1'b1; in_op = 3'b001; in_src1 = 64'd5; in_src2 = 64'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", {62'd0, in_ready, out_valid}, 64'd2);

    // Result holds while the consumer stalls.
    in_valid = 1'b1; in_op = 3'b000; in_src1 = 64'd100; in_src2 = 64'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (64) begin @(posedge clk); #1; end
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_result", out_result, 64'd14);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold_released", {62'd0, in_ready, out_valid}, 64'd2);

    // Reset mid-CALC returns every output to its reset value.
    in_valid = 1'b1; in_op = 3'b001; in_src1 = 64'd12345; in_src2 = 64'd11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_out_result", out_result, 64'd0);

    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0:       b = 64'd0;
        1:       b = 64'($urandom_range(1, 15));
        2:       b = '1;
        3:       b = -64'($urandom_range(1, 15));
        default: b = {$urandom, $urandom} >> $urandom_range(0, 63);
      endcase
      if ($urandom_range(0, 7) == 0) a = op[2] ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
      do_op(op, a, b, ref_model(op, a, b), $sformatf("rand%0d_op%0d", n, op));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
